fetch_unit: RTL and testbench

Instruction-fetch stage that consumes the program counter value (pc_in) and drives the next-PC value (pc_next) that the PC register loads every clock.
It issues requests to instruction memory over a req/ack handshake and fills the IF/ID pipeline buffer (ifid_*).
It holds the PC while memory is slow or decode is stalled, uses a one-entry skid buffer to absorb a late stall, and redirects on taken branches.

---
 rtl/fetch_unit.sv | 138 +++++++++++++
 tb/tb_fetch_unit.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch: drives next-PC, issues imem requests, fills the IF/ID buffer.
// Latency: imem ack to ifid_valid takes one cycle; a zero-wait memory sustains one instruction per cycle.
// Backpressure: id_stall holds the PC; a word acked during a stall waits in a one-entry skid buffer.
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_in,
   output logic [31:0] pc_next,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        id_stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic        ifid_valid,
   output logic [31:0] ifid_instr,
   output logic [31:0] ifid_pc4
);

   localparam logic [1:0] FETCH = 2'd0;
   localparam logic [1:0] SKID  = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;

   logic [1:0]  state_q, state_d;
   logic        ifid_valid_q, ifid_valid_d;
   logic [31:0] ifid_instr_q, ifid_instr_d;
   logic [31:0] ifid_pc4_q, ifid_pc4_d;
   logic [31:0] skid_instr_q, skid_instr_d;
   logic [31:0] skid_pc4_q, skid_pc4_d;
   logic [31:0] drain_addr_q, drain_addr_d;

   logic [31:0] pc4;
   logic        accept;

   assign pc4    = pc_in + 32'd4;
   // An empty IF/ID buffer may always be overwritten, whatever decode says.
   assign accept = !ifid_valid_q || !id_stall;

   always_comb begin
      state_d      = state_q;
      ifid_valid_d = ifid_valid_q;
      ifid_instr_d = ifid_instr_q;
      ifid_pc4_d   = ifid_pc4_q;
      skid_instr_d = skid_instr_q;
      skid_pc4_d   = skid_pc4_q;
      drain_addr_d = drain_addr_q;
      imem_req     = 1'b0;
      imem_addr    = pc_in;
      pc_next      = pc_in;

      if (rst) begin
         pc_next = RESET_PC;
      end else begin
         case (state_q)
            FETCH: begin
               imem_req = 1'b1;
               if (branch_taken) begin
                  ifid_valid_d = 1'b0;
                  pc_next      = branch_target;
                  if (!imem_ack) begin
                     drain_addr_d = pc_in;
                     state_d      = DRAIN;
                  end
               end else if (imem_ack) begin
                  pc_next = pc4;
                  if (accept) begin
                     ifid_valid_d = 1'b1;
                     ifid_instr_d = imem_rdata;
                     ifid_pc4_d   = pc4;
                  end else begin
                     skid_instr_d = imem_rdata;
                     skid_pc4_d   = pc4;
                     state_d      = SKID;
                  end
               end else if (!id_stall) begin
                  ifid_valid_d = 1'b0;
               end
            end
            SKID: begin
               if (branch_taken) begin
                  ifid_valid_d = 1'b0;
                  pc_next      = branch_target;
                  state_d      = FETCH;
               end else if (!id_stall) begin
                  ifid_valid_d = 1'b1;
                  ifid_instr_d = skid_instr_q;
                  ifid_pc4_d   = skid_pc4_q;
                  state_d      = FETCH;
               end
            end
            DRAIN: begin
               // The flushed request must still complete at its original address.
               imem_req  = 1'b1;
               imem_addr = drain_addr_q;
               if (branch_taken) begin
                  ifid_valid_d = 1'b0;
                  pc_next      = branch_target;
               end
               if (imem_ack) begin
                  state_d = FETCH;
               end
            end
            default: begin
               state_d = FETCH;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= FETCH;
         ifid_valid_q <= 1'b0;
         ifid_instr_q <= NOP_INSTR;
         ifid_pc4_q   <= 32'h0000_0000;
         skid_instr_q <= 32'h0000_0000;
         skid_pc4_q   <= 32'h0000_0000;
         drain_addr_q <= 32'h0000_0000;
      end else begin
         state_q      <= state_d;
         ifid_valid_q <= ifid_valid_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_pc4_q   <= ifid_pc4_d;
         skid_instr_q <= skid_instr_d;
         skid_pc4_q   <= skid_pc4_d;
         drain_addr_q <= drain_addr_d;
      end
   end

   assign ifid_valid = ifid_valid_q;
   assign ifid_instr = ifid_instr_q;
   assign ifid_pc4   = ifid_pc4_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: models the PC register and memory, scoreboards delivered instructions.
// Each cycle step drives inputs after negedge and samples just before the next posedge.
module tb_fetch_unit;

   logic        clk;
   logic        rst;
   logic [31:0] pc_in;
   logic [31:0] pc_next;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        id_stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        ifid_valid;
   logic [31:0] ifid_instr;
   logic [31:0] ifid_pc4;

   int          n_cmp;
   int          n_err;
   logic [63:0] exp_q[$];
   logic        push_on_ack;
   logic [31:0] s_pc_next;
   logic        s_req;
   logic [31:0] s_addr;

   fetch_unit #(
      .RESET_PC (32'h0000_0000),
      .NOP_INSTR(32'h0000_0000)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .pc_in        (pc_in),
      .pc_next      (pc_next),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ack     (imem_ack),
      .imem_rdata   (imem_rdata),
      .id_stall     (id_stall),
      .branch_taken (branch_taken),
      .branch_target(branch_target),
      .ifid_valid   (ifid_valid),
      .ifid_instr   (ifid_instr),
      .ifid_pc4     (ifid_pc4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock: memory answers, outputs are sampled, decode consumes, PC register loads.
   task automatic cyc();
      logic [63:0] e;
      imem_rdata = 32'h2000_0000 + imem_addr;
      #1;
      s_pc_next = pc_next;
      s_req     = imem_req;
      s_addr    = imem_addr;
      if (push_on_ack && imem_req && imem_ack && !branch_taken && !rst)
         exp_q.push_back({imem_rdata, imem_addr + 32'd4});
      if (ifid_valid && !id_stall && !branch_taken && !rst) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL sb_extra got=%h/%h required=nothing", ifid_instr, ifid_pc4);
         end else begin
            e = exp_q.pop_front();
            if ({ifid_instr, ifid_pc4} !== e) begin
               n_err++;
               $display("FAIL sb_order got=%h/%h required=%h/%h", ifid_instr, ifid_pc4, e[63:32], e[31:0]);
            end
         end
      end
      @(posedge clk);
      #1;
      pc_in = s_pc_next;
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; imem_ack = 1'b0; id_stall = 1'b0; branch_taken = 1'b0;
      pc_in = 32'h0000_1234;
      for (int i = 0; i < 2; i++) begin
         cyc();
         n_cmp++;
         if (s_pc_next !== 32'h0 || s_req !== 1'b0) begin
            n_err++;
            $display("FAIL rst_out[%0d] got pc_next=%h req=%b required 0/0", i, s_pc_next, s_req);
         end
      end
      n_cmp++;
      if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0 || ifid_pc4 !== 32'h0) begin
         n_err++;
         $display("FAIL rst_ifid got=%b/%h/%h required 0/0/0", ifid_valid, ifid_instr, ifid_pc4);
      end
   endtask

   task automatic test_stream();
      logic [31:0] a;
      rst = 1'b0; imem_ack = 1'b1; id_stall = 1'b0;
      for (int i = 0; i < 4; i++) begin
         a = 32'(4 * i);
         exp_q.push_back({32'h2000_0000 + a, a + 32'd4});
      end
      for (int i = 0; i < 4; i++) begin
         a = 32'(4 * i);
         cyc();
         n_cmp++;
         if (s_pc_next !== a + 32'd4) begin
            n_err++;
            $display("FAIL stream_pc[%0d] got=%h required=%h", i, s_pc_next, a + 32'd4);
         end
         if (i < 2) begin
            n_cmp++;
            if (ifid_valid !== 1'b1 || ifid_instr !== 32'h2000_0000 + a) begin
               n_err++;
               $display("FAIL stream_ifid[%0d] got=%b/%h required=1/%h", i, ifid_valid, ifid_instr, 32'h2000_0000 + a);
            end
         end
      end
      imem_ack = 1'b0;
      cyc();
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL stream_left got=%0d required=0", exp_q.size());
      end
   endtask

   task automatic test_wait();
      branch_taken = 1'b1; branch_target = 32'h40; imem_ack = 1'b1;
      cyc();
      branch_taken = 1'b0; imem_ack = 1'b0;
      for (int i = 0; i < 2; i++) begin
         cyc();
         n_cmp++;
         if (s_pc_next !== 32'h40 || ifid_valid !== 1'b0) begin
            n_err++;
            $display("FAIL wait_hold[%0d] got=%h/%b required=00000040/0", i, s_pc_next, ifid_valid);
         end
      end
      imem_ack = 1'b1;
      exp_q.push_back({32'h2000_0040, 32'h44});
      cyc();
      n_cmp++;
      if (s_pc_next !== 32'h44 || ifid_valid !== 1'b1 || ifid_pc4 !== 32'h44) begin
         n_err++;
         $display("FAIL wait_ack got=%h/%b/%h required=00000044/1/00000044", s_pc_next, ifid_valid, ifid_pc4);
      end
      imem_ack = 1'b0;
      cyc();
   endtask

   task automatic test_skid();
      imem_ack = 1'b1; id_stall = 1'b0;
      exp_q.push_back({32'h2000_0044, 32'h48});
      cyc();
      id_stall = 1'b1;
      exp_q.push_back({32'h2000_0048, 32'h4C});
      cyc();
      n_cmp++;
      if (s_pc_next !== 32'h4C) begin
         n_err++;
         $display("FAIL skid_enter got=%h required=0000004c", s_pc_next);
      end
      cyc();
      n_cmp++;
      if (s_req !== 1'b0 || s_pc_next !== 32'h4C || ifid_instr !== 32'h2000_0044) begin
         n_err++;
         $display("FAIL skid_hold got=%b/%h/%h required=0/0000004c/20000044", s_req, s_pc_next, ifid_instr);
      end
      id_stall = 1'b0; imem_ack = 1'b0;
      cyc();
      n_cmp++;
      if (ifid_valid !== 1'b1 || ifid_instr !== 32'h2000_0048 || ifid_pc4 !== 32'h4C) begin
         n_err++;
         $display("FAIL skid_release got=%b/%h/%h required=1/20000048/0000004c", ifid_valid, ifid_instr, ifid_pc4);
      end
      cyc();
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL skid_left got=%0d required=0", exp_q.size());
      end
   endtask

   task automatic test_branch_drain();
      branch_taken = 1'b1; branch_target = 32'h20; imem_ack = 1'b1;
      cyc();
      branch_taken = 1'b0; imem_ack = 1'b0;
      cyc();
      branch_taken = 1'b1; branch_target = 32'h100;
      cyc();
      n_cmp++;
      if (s_pc_next !== 32'h100) begin
         n_err++;
         $display("FAIL br_target got=%h required=00000100", s_pc_next);
      end
      branch_taken = 1'b0;
      for (int i = 0; i < 2; i++) begin
         cyc();
         n_cmp++;
         if (s_req !== 1'b1 || s_addr !== 32'h20 || s_pc_next !== 32'h100 || ifid_valid !== 1'b0) begin
            n_err++;
            $display("FAIL br_drain[%0d] got=%b/%h/%h/%b required=1/00000020/00000100/0", i, s_req, s_addr, s_pc_next, ifid_valid);
         end
      end
      imem_ack = 1'b1;
      cyc();
      n_cmp++;
      if (s_addr !== 32'h20 || ifid_valid !== 1'b0) begin
         n_err++;
         $display("FAIL br_discard got=%h/%b required=00000020/0", s_addr, ifid_valid);
      end
      imem_ack = 1'b0;
      cyc();
      n_cmp++;
      if (s_req !== 1'b1 || s_addr !== 32'h100 || ifid_valid !== 1'b0) begin
         n_err++;
         $display("FAIL br_refetch got=%b/%h/%b required=1/00000100/0", s_req, s_addr, ifid_valid);
      end
      imem_ack = 1'b1;
      exp_q.push_back({32'h2000_0100, 32'h104});
      cyc();
      imem_ack = 1'b0;
      cyc();
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL br_left got=%0d required=0", exp_q.size());
      end
   endtask

   task automatic test_wrap();
      branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC; imem_ack = 1'b1;
      cyc();
      branch_taken = 1'b0;
      exp_q.push_back({32'h1FFF_FFFC, 32'h0});
      cyc();
      n_cmp++;
      if (s_pc_next !== 32'h0 || ifid_pc4 !== 32'h0 || ifid_valid !== 1'b1) begin
         n_err++;
         $display("FAIL wrap got=%h/%h/%b required=00000000/00000000/1", s_pc_next, ifid_pc4, ifid_valid);
      end
      imem_ack = 1'b0;
      cyc();
   endtask

   task automatic test_rst_skid();
      imem_ack = 1'b1; id_stall = 1'b0;
      cyc();
      id_stall = 1'b1;
      cyc();
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         cyc();
         n_cmp++;
         if (s_pc_next !== 32'h0 || s_req !== 1'b0 || ifid_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_skid[%0d] got=%h/%b/%b required=00000000/0/0", i, s_pc_next, s_req, ifid_valid);
         end
      end
      rst = 1'b0; imem_ack = 1'b0;
      cyc();
      n_cmp++;
      if (s_req !== 1'b1 || s_addr !== 32'h0 || exp_q.size() != 0) begin
         n_err++;
         $display("FAIL rst_fetch got=%b/%h/%0d required=1/00000000/0", s_req, s_addr, exp_q.size());
      end
   endtask

   task automatic test_back_to_back();
      push_on_ack = 1'b1;
      for (int i = 0; i < 300; i++) begin
         imem_ack = 1'($urandom_range(0, 1));
         id_stall = ($urandom_range(0, 3) == 0);
         cyc();
      end
      push_on_ack = 1'b0; imem_ack = 1'b0; id_stall = 1'b0;
      for (int i = 0; i < 4; i++) cyc();
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL b2b_left got=%0d required=0", exp_q.size());
      end
   endtask

   initial begin
      n_cmp = 0; n_err = 0; push_on_ack = 1'b0;
      rst = 1'b1; pc_in = 32'h0; imem_ack = 1'b0; imem_rdata = 32'h0;
      id_stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
      @(negedge clk);
      #1;
      test_reset();
      test_stream();
      test_wait();
      test_skid();
      test_branch_drain();
      test_wrap();
      test_rst_skid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
